// File: rtl/edge_stream_receiver.sv
// -----------------------------------------------------------------------------
// edge_stream_receiver
//
// Receives the one-bit-per-cycle edge stream sent by the edge-map buffer. It
// tracks the position of the next pixel in the frame and packs the bits, MSB
// first, into WORD-bit words. The words go downstream over a valid/ready
// handshake. The block also counts edge pixels, reports frame completion and
// flags dropped words.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle pulse; arms a new frame from IDLE or DONE
//   bitIn      serial edge bit
//   bitValid   bitIn carries a pixel this cycle
//   wordOut    packed word; first-received bit in the MSB
//   wordValid  wordOut holds an unconsumed word
//   wordReady  downstream consumes wordOut this cycle
//   pixelIdx   index of the next expected pixel (counts down)
//   edgeCount  number of 1-bits accepted this frame (saturating)
//   busy       high while receiving or flushing
//   complete   frame fully handed off
//   overrun    sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module edge_stream_receiver #(
  parameter int PIXELS = 22500,
  parameter int WORD   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            bitIn,
  input  logic            bitValid,
  output logic [WORD-1:0] wordOut,
  output logic            wordValid,
  input  logic            wordReady,
  output logic [14:0]     pixelIdx,
  output logic [14:0]     edgeCount,
  output logic            busy,
  output logic            complete,
  output logic            overrun
);

  localparam int                FILL_W    = $clog2(WORD);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD - 1);
  localparam logic [FILL_W:0]   WORD_V    = (FILL_W + 1)'(WORD);
  localparam logic [14:0]       IDX_FIRST = 15'(PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WORD-1:0]   r_shift;
  logic [FILL_W-1:0] r_fill;
  logic [WORD-1:0]   r_out;
  logic              r_valid;
  logic [14:0]       r_idx;
  logic [14:0]       r_edge;
  logic              r_overrun;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last_bit;
  logic [WORD-1:0]   w_shift_in;
  logic              w_word_done;
  logic              w_pop;
  logic              w_out_free;
  logic              w_tail_load;
  logic [FILL_W:0]   w_pad_amt;
  logic [WORD-1:0]   w_tail_word;

  // start only takes effect when no frame is in progress.
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept    = (r_state == S_RECV) && bitValid;
  assign w_last_bit  = w_accept && (r_idx == '0);
  assign w_shift_in  = {r_shift[WORD-2:0], bitIn};
  assign w_word_done = w_accept && (r_fill == FILL_LAST);
  assign w_pop       = r_valid && wordReady;
  // The output register can take a new word if it is empty or is being
  // emptied on this same edge.
  assign w_out_free  = !r_valid || w_pop;
  assign w_tail_load = (r_state == S_FLUSH) && (r_fill != '0) && w_out_free;
  // Left-justify the partial word so that the received bits sit in the MSBs
  // and the unused LSBs are zero.
  assign w_pad_amt   = WORD_V - {1'b0, r_fill};
  assign w_tail_word = r_shift << w_pad_amt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RECV;
      S_RECV:  if (w_last_bit) w_state_next = S_FLUSH;
      // Leave only after the partial word is out and the last word held in
      // the output register has been consumed.
      S_FLUSH: if ((r_fill == '0) && w_out_free) w_state_next = S_DONE;
      S_DONE:  if (start) w_state_next = S_RECV;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_fill    <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_idx     <= IDX_FIRST;
      r_edge    <= '0;
      r_overrun <= 1'b0;
    end else begin
      // Output register. A full word and a tail word never load on the
      // same edge, because each can load in only one of RECV and FLUSH.
      if (w_word_done && w_out_free) begin
        r_out   <= w_shift_in;
        r_valid <= 1'b1;
      end else if (w_tail_load) begin
        r_out   <= w_tail_word;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end

      if (w_start_ok) begin
        r_shift   <= '0;
        r_fill    <= '0;
        r_idx     <= IDX_FIRST;
        r_edge    <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_accept) begin
          if (w_word_done) begin
            r_shift <= '0;
            r_fill  <= '0;
            // A full word with nowhere to go is dropped. Reception continues.
            if (!w_out_free) r_overrun <= 1'b1;
          end else begin
            r_shift <= w_shift_in;
            r_fill  <= r_fill + FILL_W'(1);
          end
          // pixelIdx holds at 0 after the final bit of the frame.
          if (r_idx != '0) r_idx <= r_idx - 15'd1;
          if (bitIn && (r_edge != '1)) r_edge <= r_edge + 15'd1;
        end
        if (w_tail_load) begin
          r_shift <= '0;
          r_fill  <= '0;
        end
      end
    end
  end

  assign wordOut   = r_out;
  assign wordValid = r_valid;
  assign pixelIdx  = r_idx;
  assign edgeCount = r_edge;
  assign overrun   = r_overrun;
  assign busy      = (r_state == S_RECV) || (r_state == S_FLUSH);
  assign complete  = (r_state == S_DONE);

endmodule

// File: tb/tb_edge_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_edge_stream_receiver
//
// Scoreboard bench for edge_stream_receiver. Each bit that is driven is also
// packed by a small bench model. When the model completes a word, that word is
// pushed to a queue. A negedge monitor pops the queue and compares on every
// output handshake. Each scenario task checks its own status outputs inline.
// -----------------------------------------------------------------------------
module tb_edge_stream_receiver;

  localparam int PIXELS = 22500;
  localparam int WORD   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        bitIn = 1'b0;
  logic        bitValid = 1'b0;
  logic        wordReady = 1'b0;
  logic [7:0]  wordOut;
  logic        wordValid;
  logic [14:0] pixelIdx;
  logic [14:0] edgeCount;
  logic        busy;
  logic        complete;
  logic        overrun;

  always #5 clk = ~clk;

  edge_stream_receiver #(.PIXELS(PIXELS), .WORD(WORD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bitIn     (bitIn),
    .bitValid  (bitValid),
    .wordOut   (wordOut),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .pixelIdx  (pixelIdx),
    .edgeCount (edgeCount),
    .busy      (busy),
    .complete  (complete),
    .overrun   (overrun)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] acc;
  int         acc_cnt;
  int         word_idx;
  int         drop_idx;
  int         bits_sent;
  int         exp_edges;
  int         cycle_cnt = 0;
  int         hs_cycle  = 0;
  int         words_seen = 0;
  logic [7:0] mon_exp;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Inputs change at posedge+1, so the values seen here are the ones the next
  // rising edge will sample.
  always @(negedge clk) begin
    if (reset && wordValid && wordReady) begin
      hs_cycle = cycle_cnt;
      words_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got %h, scoreboard empty", wordOut);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wordOut !== mon_exp) begin
          n_fail++;
          $display("FAIL word_data #%0d: got %h, expected %h", words_seen, wordOut, mon_exp);
        end
      end
      $display("word %0d handshake: %h", words_seen, wordOut);
    end
  end

  task automatic clear_model();
    exp_q.delete();
    acc       = '0;
    acc_cnt   = 0;
    word_idx  = 0;
    drop_idx  = -1;
    bits_sent = 0;
    exp_edges = 0;
  endtask

  task automatic model_bit(input logic b);
    acc = {acc[6:0], b};
    acc_cnt++;
    bits_sent++;
    if (b) exp_edges++;
    if (acc_cnt == 8) begin
      if (word_idx != drop_idx) exp_q.push_back(acc);
      word_idx++;
      acc_cnt = 0;
      acc     = '0;
    end
  endtask

  task automatic model_tail();
    if (acc_cnt > 0) exp_q.push_back(acc << (8 - acc_cnt));
    acc_cnt = 0;
    acc     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bitIn    = b;
    bitValid = 1'b1;
    model_bit(b);
    tick();
    bitValid = 1'b0;
  endtask

  task automatic idle_cycle();
    bitValid = 1'b0;
    bitIn    = 1'b0;
    tick();
  endtask

  task automatic do_start();
    clear_model();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for complete, with a cycle budget. Returns the number of cycles
  // between the last output handshake and complete going high.
  task automatic wait_complete(output bit found, output int lat);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (complete === 1'b1) begin
        found = 1'b1;
        lat   = cycle_cnt - hs_cycle;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 7;
    if (wordOut !== 8'h00)        begin n_fail++; $display("FAIL rst_wordOut: got %h, expected 00", wordOut); end
    if (wordValid !== 1'b0)       begin n_fail++; $display("FAIL rst_wordValid: got %b, expected 0", wordValid); end
    if (pixelIdx !== 15'd22499)   begin n_fail++; $display("FAIL rst_pixelIdx: got %0d, expected 22499", pixelIdx); end
    if (edgeCount !== 15'd0)      begin n_fail++; $display("FAIL rst_edgeCount: got %0d, expected 0", edgeCount); end
    if (busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (complete !== 1'b0)        begin n_fail++; $display("FAIL rst_complete: got %b, expected 0", complete); end
    if (overrun !== 1'b0)         begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
    reset = 1'b1;
    tick();
    // bitValid must be ignored in IDLE.
    bitValid = 1'b1;
    bitIn    = 1'b1;
    repeat (5) tick();
    bitValid = 1'b0;
    n_checks += 2;
    if (pixelIdx !== 15'd22499) begin n_fail++; $display("FAIL idle_pixelIdx: got %0d, expected 22499", pixelIdx); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_reset_mid_frame();
    wordReady = 1'b1;
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b, expected 1", busy); end
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
    n_checks++;
    if (pixelIdx !== 15'(PIXELS - 1 - 100)) begin n_fail++; $display("FAIL mid_pixelIdx: got %0d, expected %0d", pixelIdx, PIXELS - 101); end
    reset = 1'b0;
    #2;
    exp_q.delete();
    n_checks += 6;
    if (wordValid !== 1'b0)     begin n_fail++; $display("FAIL midrst_wordValid: got %b, expected 0", wordValid); end
    if (wordOut !== 8'h00)      begin n_fail++; $display("FAIL midrst_wordOut: got %h, expected 00", wordOut); end
    if (pixelIdx !== 15'd22499) begin n_fail++; $display("FAIL midrst_pixelIdx: got %0d, expected 22499", pixelIdx); end
    if (edgeCount !== 15'd0)    begin n_fail++; $display("FAIL midrst_edgeCount: got %0d, expected 0", edgeCount); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    if (overrun !== 1'b0)       begin n_fail++; $display("FAIL midrst_overrun: got %b, expected 0", overrun); end
    tick();
    reset = 1'b1;
    tick();
    bitValid = 1'b1;
    bitIn    = 1'b1;
    repeat (20) tick();
    bitValid = 1'b0;
    n_checks += 3;
    if (pixelIdx !== 15'd22499) begin n_fail++; $display("FAIL postrst_pixelIdx: got %0d, expected 22499", pixelIdx); end
    if (edgeCount !== 15'd0)    begin n_fail++; $display("FAIL postrst_edgeCount: got %0d, expected 0", edgeCount); end
    if (wordValid !== 1'b0)     begin n_fail++; $display("FAIL postrst_wordValid: got %b, expected 0", wordValid); end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_all_ones();
    bit found;
    int lat;
    wordReady = 1'b1;
    do_start();
    for (int i = 0; i < PIXELS; i++) send_bit(1'b1);
    model_tail();
    n_checks += 3;
    if (edgeCount !== 15'd22500) begin n_fail++; $display("FAIL ones_edgeCount: got %0d, expected 22500", edgeCount); end
    if (overrun !== 1'b0)        begin n_fail++; $display("FAIL ones_overrun: got %b, expected 0", overrun); end
    if (busy !== 1'b1)           begin n_fail++; $display("FAIL ones_busy_flush: got %b, expected 1", busy); end
    wait_complete(found, lat);
    n_checks += 4;
    if (!found)                 begin n_fail++; $display("FAIL ones_complete: complete never rose within 64 cycles"); end
    if (lat != 1)               begin n_fail++; $display("FAIL ones_complete_lat: got %0d cycles after tail handshake, expected 1", lat); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL ones_busy_done: got %b, expected 0", busy); end
    if (exp_q.size() != 0)      begin n_fail++; $display("FAIL ones_words_left: %0d words never delivered, expected 0", exp_q.size()); end
    $display("test_all_ones done");
  endtask

  task automatic test_alternating();
    bit found;
    int lat;
    wordReady = 1'b1;
    do_start();
    n_checks += 2;
    if (complete !== 1'b0)   begin n_fail++; $display("FAIL alt_complete_clear: got %b, expected 0", complete); end
    if (edgeCount !== 15'd0) begin n_fail++; $display("FAIL alt_edge_clear: got %0d, expected 0", edgeCount); end
    for (int i = 0; i < PIXELS; i++) begin
      n_checks++;
      if (pixelIdx !== 15'(PIXELS - 1 - i)) begin
        n_fail++;
        $display("FAIL alt_pixelIdx: got %0d, expected %0d", pixelIdx, PIXELS - 1 - i);
      end
      send_bit((i % 2) == 0);
    end
    model_tail();
    n_checks += 2;
    if (pixelIdx !== 15'd0)      begin n_fail++; $display("FAIL alt_pixelIdx_end: got %0d, expected 0", pixelIdx); end
    if (edgeCount !== 15'd11250) begin n_fail++; $display("FAIL alt_edgeCount: got %0d, expected 11250", edgeCount); end
    wait_complete(found, lat);
    n_checks += 3;
    if (!found)            begin n_fail++; $display("FAIL alt_complete: complete never rose within 64 cycles"); end
    if (lat != 1)          begin n_fail++; $display("FAIL alt_complete_lat: got %0d, expected 1", lat); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL alt_words_left: %0d words never delivered, expected 0", exp_q.size()); end
    $display("test_alternating done");
  endtask

  // Starts frame 3. The output handshake and the 8th bit of the next word
  // land on the same edge.
  task automatic test_handshake_same_edge();
    wordReady = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    wordReady = 1'b1;
    send_bit(1'($urandom_range(0, 1)));
    wordReady = 1'b0;
    n_checks += 3;
    if (overrun !== 1'b0)   begin n_fail++; $display("FAIL same_edge_overrun: got %b, expected 0", overrun); end
    if (wordValid !== 1'b1) begin n_fail++; $display("FAIL same_edge_valid: got %b, expected 1", wordValid); end
    if (exp_q.size() == 0 || wordOut !== exp_q[0]) begin
      n_fail++;
      $display("FAIL same_edge_word: got %h, expected next scoreboard word (queue size %0d)", wordOut, exp_q.size());
    end
    wordReady = 1'b1;
    idle_cycle();
    wordReady = 1'b0;
    n_checks++;
    if (wordValid !== 1'b0) begin n_fail++; $display("FAIL same_edge_drain: got %b, expected 0", wordValid); end
    $display("test_handshake_same_edge done");
  endtask

  task automatic test_overrun();
    wordReady = 1'b0;
    drop_idx  = word_idx + 1;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    n_checks += 3;
    if (overrun !== 1'b1)   begin n_fail++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
    if (wordValid !== 1'b1) begin n_fail++; $display("FAIL overrun_held_valid: got %b, expected 1", wordValid); end
    if (exp_q.size() == 0 || wordOut !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overrun_held_word: got %h, expected first held word (queue size %0d)", wordOut, exp_q.size());
    end
    wordReady = 1'b1;
    $display("test_overrun done");
  endtask

  // Bits arrive on every 3rd cycle, and a start pulse is sent mid-stream. The
  // rest of the frame then runs at full rate.
  task automatic test_gaps_and_start();
    bit found;
    int lat;
    wordReady = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      if (i == 24) start = 1'b1;
      idle_cycle();
      start = 1'b0;
      idle_cycle();
    end
    n_checks += 4;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got %b, expected 1", busy); end
    if (pixelIdx !== 15'(PIXELS - 1 - bits_sent)) begin n_fail++; $display("FAIL gap_pixelIdx: got %0d, expected %0d", pixelIdx, PIXELS - 1 - bits_sent); end
    if (edgeCount !== 15'(exp_edges)) begin n_fail++; $display("FAIL gap_edgeCount: got %0d, expected %0d", edgeCount, exp_edges); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL gap_overrun_sticky: got %b, expected 1", overrun); end
    while (bits_sent < PIXELS) send_bit(1'($urandom_range(0, 1)));
    model_tail();
    n_checks += 2;
    if (edgeCount !== 15'(exp_edges)) begin n_fail++; $display("FAIL f3_edgeCount: got %0d, expected %0d", edgeCount, exp_edges); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL f3_overrun_end: got %b, expected 1", overrun); end
    wait_complete(found, lat);
    n_checks += 3;
    if (!found)            begin n_fail++; $display("FAIL f3_complete: complete never rose within 64 cycles"); end
    if (lat != 1)          begin n_fail++; $display("FAIL f3_complete_lat: got %0d, expected 1", lat); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL f3_words_left: %0d words never delivered, expected 0", exp_q.size()); end
    $display("test_gaps_and_start done");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_reset_mid_frame();
    test_all_ones();
    test_alternating();
    test_handshake_same_edge();
    test_overrun();
    test_gaps_and_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_stream_receiver.md
# edge_stream_receiver

Consumer end of the edge-map buffer's serial send path. Accepts the one-bit-per-cycle edge stream that the buffer emits in SEND mode, tracks pixel position within the 150×150 frame, and packs the bits into bytes for the downstream OR/combine stage. It presents those bytes over a valid/ready handshake. It also counts edge pixels and flags frame completion and data loss.

## Interface
- PIXELS, default 22500: bits per frame, equal to 150×150.
- WORD, default 8: bits packed per output word.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that arms reception of a new frame.
- bitIn  input  1  serial edge bit from the buffer.
- bitValid  input  1  bitIn carries a pixel this cycle.
- wordOut  output  WORD  packed pixels; the first-received bit is in the MSB.
- wordValid  output  1  wordOut holds an unconsumed word.
- wordReady  input  1  downstream accepts wordOut this cycle.
- pixelIdx  output  15  index of the next expected pixel.
- edgeCount  output  15  number of 1-bits accepted in the current frame.
- busy  output  1  high in RECV and FLUSH.
- complete  output  1  frame fully handed off.
- overrun  output  1  sticky flag: a completed word was dropped.

## Operation
- States and transitions:
  - IDLE → RECV on start.
  - RECV → FLUSH after the PIXELS-th accepted bit.
  - FLUSH → DONE once the last word (full or padded) has been accepted by downstream.
  - DONE → RECV on start.
- Pixel order is descending, matching the buffer's send order.
  - On start, pixelIdx loads PIXELS-1.
  - Each accepted bit decrements pixelIdx.
  - The bit accepted with pixelIdx=0 is the final bit of the frame.
- An accepted bit is one where bitValid=1 while in RECV. bitValid is ignored in IDLE, FLUSH and DONE.
- Packing:
  - Accepted bits shift into a WORD-bit shift register, MSB first.
  - A 3-bit fill counter tracks the bits held.
  - When the WORD-th bit arrives, the word moves to the output register.
- Output register:
  - Holds one word; wordValid=1 while it is occupied.
  - It empties on a clock edge with wordValid && wordReady.
- Overrun:
  - Occurs when a word completes while the output register is still occupied and is not being emptied that same edge.
  - The new word is dropped, overrun sets, and reception continues.
  - overrun clears only on reset or start.
- Simultaneous handshake and word completion on the same edge: the old word is consumed and the new word loads. There is no overrun.
- Frame tail: 22500 mod 8 = 4, so the last word holds 4 data bits in [7:4] with [3:0] zero-padded.
  - In FLUSH, a partial word moves to the output register as soon as it is free.
  - If the fill count is 0, no padding word is produced.
- edgeCount:
  - Increments on each accepted 1-bit and saturates at 32767. The maximum reachable value is 22500.
  - Clears on start.
- start received while in RECV or FLUSH is ignored.
- Reset mid-frame returns the block to IDLE and discards all partial and held data.

## Timing
- Reset values: state IDLE, wordOut=0, wordValid=0, pixelIdx=PIXELS-1, edgeCount=0, busy=0, complete=0, overrun=0.
- After start is sampled: busy=1 on the next cycle, and bitValid is honoured from that cycle onward.
- Word latency: wordValid rises on the cycle after the edge that accepts the WORD-th bit, when the output register is free.
- wordOut and wordValid stay stable until the handshake edge.
- A full-rate stream can run without overrun when wordReady is high at least once every 8 cycles.
- After the final bit:
  - FLUSH loads the tail word on the next edge if the output register is free.
  - complete=1 and busy=0 on the cycle after the tail word's handshake.
- complete holds high in DONE and clears on the cycle after start.

## Test plan
- Reset mid-frame: assert reset after 100 bits → all outputs return to reset values immediately, and the block ignores bitValid until the next start.
- Stream of 22500 ones with wordReady=1:
  - 2812 words of 8'hFF, then a tail word of 8'hF0.
  - edgeCount=22500, complete=1 one cycle after the tail handshake, overrun=0.
- Alternating pattern 1,0,1,0…:
  - Every word is 8'hAA and the tail word is 8'hA0; edgeCount=11250.
  - pixelIdx steps 22499→0.
- wordReady held low for 16 bits at full rate: the first word is held, the second word is dropped, and overrun=1 stays set through the rest of the frame.
- Handshake on the same edge the 8th bit of the next word arrives: no overrun, and the next word appears the following cycle.
- bitValid gaps (bits valid every 3rd cycle), plus a start pulse during RECV: the stream packs correctly, and the start pulse has no effect.
